// File: rtl/mean_divider.sv
// Per-cluster mean update: a serial restoring divider divides the R/G/B sums by the pixel count in parallel.
// It emits a saturated 8-bit-per-channel mean and a flag that is set when the new mean differs from the old one.
module mean_divider #(
    parameter int SUM_W  = 26,
    parameter int CNT_W  = 14,
    parameter int IDX_W  = 4,
    parameter int THRESH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [SUM_W-1:0] in_sum_r,
    input  logic [SUM_W-1:0] in_sum_g,
    input  logic [SUM_W-1:0] in_sum_b,
    input  logic [CNT_W-1:0] in_count,
    input  logic [23:0]      in_old_mean,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [23:0]      out_mean,
    output logic             out_changed
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // DIV   | one quotient bit per cycle, SUM_W cycles
    // CHECK | saturate quotients, compare with old mean, load outputs
    // HOLD  | out_valid high until consumer accepts
    typedef enum logic [1:0] {IDLE, DIV, CHECK, HOLD} state_t;

    localparam int BC_W = $clog2(SUM_W);
    localparam logic [8:0] THR = 9'(THRESH);

    state_t state, state_nx;

    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          count_q;
    logic [23:0]               old_q;
    logic [BC_W-1:0]           bit_cnt;
    logic [2:0][SUM_W-1:0]     sum_q;
    logic [2:0][SUM_W-1:0]     quo_q;
    logic [2:0][CNT_W:0]       rem_q;
    logic [2:0][CNT_W:0]       rem_sh;
    logic [2:0][CNT_W:0]       rem_nx;
    logic [2:0]                q_bit;
    logic [2:0][7:0]           sat;
    logic [2:0][7:0]           diff;
    logic                      chg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = (in_count == '0) ? CHECK : DIV;
            DIV:     if (bit_cnt == '0) state_nx = CHECK;
            CHECK:   state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The remainder always stays below count, so its top bit can be dropped before each shift.
    always_comb begin
        rem_sh = '0;
        rem_nx = '0;
        q_bit  = '0;
        for (int c = 0; c < 3; c++) begin
            rem_sh[c] = {rem_q[c][CNT_W-1:0], sum_q[c][SUM_W-1]};
            q_bit[c]  = (rem_sh[c] >= {1'b0, count_q});
            rem_nx[c] = q_bit[c] ? rem_sh[c] - {1'b0, count_q} : rem_sh[c];
        end
    end

    always_comb begin
        sat  = '0;
        diff = '0;
        chg  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sat[c]  = (|quo_q[c][SUM_W-1:8]) ? 8'hFF : quo_q[c][7:0];
            diff[c] = (sat[c] >= old_q[8*(2-c) +: 8]) ? sat[c] - old_q[8*(2-c) +: 8]
                                                      : old_q[8*(2-c) +: 8] - sat[c];
            if ({1'b0, diff[c]} > THR) chg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q       <= '0;
            count_q     <= '0;
            old_q       <= '0;
            bit_cnt     <= '0;
            sum_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            out_idx     <= '0;
            out_mean    <= '0;
            out_changed <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    idx_q    <= in_idx;
                    count_q  <= in_count;
                    old_q    <= in_old_mean;
                    sum_q[0] <= in_sum_r;
                    sum_q[1] <= in_sum_g;
                    sum_q[2] <= in_sum_b;
                    quo_q    <= '0;
                    rem_q    <= '0;
                    bit_cnt  <= BC_W'(SUM_W - 1);
                end
                DIV: begin
                    for (int c = 0; c < 3; c++) begin
                        sum_q[c] <= {sum_q[c][SUM_W-2:0], 1'b0};
                        quo_q[c] <= {quo_q[c][SUM_W-2:0], q_bit[c]};
                        rem_q[c] <= rem_nx[c];
                    end
                    bit_cnt <= bit_cnt - 1'b1;
                end
                CHECK: begin
                    out_idx <= idx_q;
                    if (count_q == '0) begin
                        out_mean    <= old_q;
                        out_changed <= 1'b0;
                    end else begin
                        out_mean    <= {sat[0], sat[1], sat[2]};
                        out_changed <= chg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
